sap_obi_to_axil_bridge: RTL
===========================

# sap_obi_to_axil_bridge

Bridges the SAP external-slave OBI manager port (`ext_slave_req_o` / `ext_slave_resp_i`) to a single AXI4-Lite manager port so SAP cores can reach SoC-side peripherals. It sits directly downstream of the SAP wrapper's external-slave output. It carries one OBI transaction at a time, translates it into AXI-Lite channel handshakes, and returns the result as an OBI `rvalid`. AXI error responses are counted and flagged.

## Interface
- `AddrWidth`, 32, OBI and AXI address width.
- `DataWidth`, 32, data width; strobe and byte-enable width is `DataWidth/8`.
- `AxProt`, 3'b000, constant value driven on `awprot` / `arprot`.
- `clk_i`  in  1  clock; single clock domain.
- `rst_i`  in  1  reset; asynchronous assert, active-high.
- `obi_req_i`, `obi_we_i`  in  1  OBI request, write enable.
- `obi_addr_i`  in  AddrWidth  OBI address.
- `obi_be_i`  in  DataWidth/8  byte enables.
- `obi_wdata_i`  in  DataWidth  write data.
- `obi_gnt_o`, `obi_rvalid_o`  out  1  grant, response valid.
- `obi_rdata_o`  out  DataWidth  read data; 0 for writes.
- `awvalid_o`/`awready_i`, `wvalid_o`/`wready_i`, `bvalid_i`/`bready_o`, `arvalid_o`/`arready_i`, `rvalid_i`/`rready_o`  1 each  AXI-Lite handshakes; `_o` are outputs, `_i` are inputs.
- `awaddr_o`, `araddr_o`  out  AddrWidth  word-aligned address.
- `awprot_o`, `arprot_o`  out  3  `AxProt`.
- `wdata_o`  out  DataWidth, `wstrb_o`  out  DataWidth/8.
- `bresp_i`, `rresp_i`  in  2; `rdata_i`  in  DataWidth.
- `err_irq_o`  out  1  sticky error flag.
- `err_clr_i`  in  1  clears the flag and the counter.
- `err_cnt_o`  out  8  saturating AXI error count.

## Operation
- FSM states: IDLE, WR, WR_B, RD_AR, RD_R, RESP.
- IDLE
  - `obi_gnt_o = obi_req_i` (combinational). Grant is given only in IDLE.
  - On `req & gnt`: latch addr, we, be, wdata.
  - If `we`, go to WR and set `aw_pend` = `w_pend` = 1. Otherwise go to RD_AR.
- WR
  - `awvalid_o = aw_pend`, `wvalid_o = w_pend`.
  - Each flag clears on its own handshake. AW and W may complete in the same cycle or in either order.
  - When both are clear (including when both complete in the same cycle), go to WR_B.
- WR_B: `bready_o = 1`. On `bvalid_i`, latch `err = (bresp_i != 2'b00)` and go to RESP.
- RD_AR: `arvalid_o = 1`. On `arready_i`, go to RD_R.
- RD_R: `rready_o = 1`. On `rvalid_i`, latch `rdata_i` and `err = (rresp_i != 2'b00)`, then go to RESP.
- RESP
  - `obi_rvalid_o = 1` for exactly one cycle; `obi_rdata_o` = latched read data, or 0 for writes.
  - Go to IDLE.
- AXI signalling rules:
  - Addresses: `{addr[AddrWidth-1:2], 2'b00}`.
  - `wstrb_o = be`.
  - Every valid is held until its ready. Nothing is dropped or retracted.
- Error reporting:
  - In RESP with `err = 1`: set `err_irq_o` and increment `err_cnt_o`, saturating at 255.
  - The OBI response itself is not altered. The read data is still returned.
- `err_clr_i` has priority over an increment in the same cycle. On that cycle the result is `err_cnt_o = 0` and `err_irq_o = 0`.
- Reset mid-transaction: everything returns to IDLE immediately and every valid drops. The AXI subordinate must be reset by the same `rst_i`.

## Timing
- Reset values: all outputs 0; state IDLE. AXI address, data and strobe outputs reset to 0.
- Write latency, with `gnt` in cycle 0:
  - AW and W valids are visible from cycle 1.
  - If AW, W and B handshake in cycles 1, 1 and 2, `obi_rvalid_o` is high in cycle 3.
- Read latency:
  - `arvalid_o` from cycle 1.
  - If AR handshakes in cycle 1 and R in cycle 2, `obi_rvalid_o` is high in cycle 3.
- Minimum issue interval between OBI transactions is 4 cycles. The next grant is possible in the cycle after RESP.
- A request held during a busy period sees `gnt = 0` until the FSM returns to IDLE.
- OBI address and data inputs are sampled only on the grant cycle.
- No combinational path from any AXI `ready`/`valid` input to any AXI `valid` output.

## Test plan
- Write, zero wait: addr 0x2000_0006, wdata 0xA5A5_1234, be 4'b0011; all readies high.
  - `awaddr = 0x2000_0004`, `wstrb = 4'b0011`.
  - `obi_rvalid_o` in cycle 3 with rdata 0.
- Read with stalls: `arready_i` low for 3 cycles, `rvalid_i` 2 cycles after AR, rdata 0xCAFE_F00D.
  - `obi_rvalid_o` is high once, with 0xCAFE_F00D.
  - `arvalid_o` stays stable throughout the stall.
- AW/W skew: `wready_i` 4 cycles before `awready_i`.
  - `wvalid_o` drops after its handshake.
  - `bready_o` asserts only after the AW handshake.
- Back-to-back: OBI `req` held high for 3 transactions.
  - Exactly 3 grants, each in IDLE, at least 4 cycles apart.
  - Responses come back in order.
- Errors:
  - A read with rresp 2'b10 gives `err_irq_o = 1`, `err_cnt_o = 1`, and the rdata is still returned.
  - 300 error responses saturate `err_cnt_o` at 255.
  - `err_clr_i` coinciding with an error gives 0 and 0.
- Reset while in WR_B: all valids low next cycle, state IDLE, `obi_rvalid_o` never asserted.

Source files
------------

// File: rtl/sap_obi_to_axil_bridge.sv
// ---------------------------------------------------------------------------
// sap_obi_to_axil_bridge
//
// Purpose: carries one OBI transaction at a time from the SAP external-slave
// manager port onto a single AXI4-Lite manager port and returns the result
// as one OBI rvalid pulse. AXI error responses raise a sticky flag and bump
// a saturating counter.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   obi_req_i/obi_we_i/obi_addr_i/obi_be_i/obi_wdata_i   OBI request side
//   obi_gnt_o/obi_rvalid_o/obi_rdata_o                   OBI grant/response
//   aw*/w*/b*/ar*/r*             AXI4-Lite manager channels
//   err_irq_o, err_cnt_o, err_clr_i   error flag, error count, clear
// ---------------------------------------------------------------------------
module sap_obi_to_axil_bridge #(
    parameter int         AddrWidth = 32,
    parameter int         DataWidth = 32,
    parameter logic [2:0] AxProt    = 3'b000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   obi_req_i,
    input  logic                   obi_we_i,
    input  logic [AddrWidth-1:0]   obi_addr_i,
    input  logic [DataWidth/8-1:0] obi_be_i,
    input  logic [DataWidth-1:0]   obi_wdata_i,
    output logic                   obi_gnt_o,
    output logic                   obi_rvalid_o,
    output logic [DataWidth-1:0]   obi_rdata_o,
    output logic                   awvalid_o,
    input  logic                   awready_i,
    output logic [AddrWidth-1:0]   awaddr_o,
    output logic [2:0]             awprot_o,
    output logic                   wvalid_o,
    input  logic                   wready_i,
    output logic [DataWidth-1:0]   wdata_o,
    output logic [DataWidth/8-1:0] wstrb_o,
    input  logic                   bvalid_i,
    output logic                   bready_o,
    input  logic [1:0]             bresp_i,
    output logic                   arvalid_o,
    input  logic                   arready_i,
    output logic [AddrWidth-1:0]   araddr_o,
    output logic [2:0]             arprot_o,
    input  logic                   rvalid_i,
    output logic                   rready_o,
    input  logic [DataWidth-1:0]   rdata_i,
    input  logic [1:0]             rresp_i,
    output logic                   err_irq_o,
    input  logic                   err_clr_i,
    output logic [7:0]             err_cnt_o
);

    localparam int BeWidth = DataWidth / 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        WR_B  = 3'd2,
        RD_AR = 3'd3,
        RD_R  = 3'd4,
        RESP  = 3'd5
    } state_t;

    state_t                 state_reg, state_next;
    logic [AddrWidth-1:2]   addr_reg;
    logic                   we_reg;
    logic [BeWidth-1:0]     be_reg;
    logic [DataWidth-1:0]   wdata_reg;
    logic [DataWidth-1:0]   rdata_reg;
    logic                   aw_pend_reg, w_pend_reg;
    logic                   err_reg;
    logic                   irq_reg;
    logic [7:0]             cnt_reg;
    logic                   grant;
    logic                   aw_left, w_left;

    // Byte offset within the word never reaches AXI (addresses are word-aligned).
    logic addr_lsb_unused;
    assign addr_lsb_unused = ^obi_addr_i[1:0];

    assign grant   = (state_reg == IDLE) && obi_req_i;
    // A pending channel stays pending unless its handshake completes this cycle.
    assign aw_left = aw_pend_reg && !awready_i;
    assign w_left  = w_pend_reg && !wready_i;

    // AXI payload comes straight from the latched request so it is stable
    // for the whole time any valid is held.
    assign awaddr_o  = {addr_reg, 2'b00};
    assign araddr_o  = {addr_reg, 2'b00};
    assign awprot_o  = AxProt;
    assign arprot_o  = AxProt;
    assign wdata_o   = wdata_reg;
    assign wstrb_o   = be_reg;
    assign err_irq_o = irq_reg;
    assign err_cnt_o = cnt_reg;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (obi_req_i) state_next = obi_we_i ? WR : RD_AR;
            WR:      if (!aw_left && !w_left) state_next = WR_B;
            WR_B:    if (bvalid_i) state_next = RESP;
            RD_AR:   if (arready_i) state_next = RD_R;
            RD_R:    if (rvalid_i) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: every AXI valid depends on registered state only.
    always_comb begin
        obi_gnt_o    = 1'b0;
        obi_rvalid_o = 1'b0;
        obi_rdata_o  = '0;
        awvalid_o    = 1'b0;
        wvalid_o     = 1'b0;
        bready_o     = 1'b0;
        arvalid_o    = 1'b0;
        rready_o     = 1'b0;
        case (state_reg)
            IDLE:  obi_gnt_o = obi_req_i;
            WR: begin
                awvalid_o = aw_pend_reg;
                wvalid_o  = w_pend_reg;
            end
            WR_B:  bready_o  = 1'b1;
            RD_AR: arvalid_o = 1'b1;
            RD_R:  rready_o  = 1'b1;
            RESP: begin
                obi_rvalid_o = 1'b1;
                obi_rdata_o  = we_reg ? '0 : rdata_reg;
            end
            default: ;
        endcase
    end

    // Request capture, channel bookkeeping, response capture, error counting
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_reg    <= '0;
            we_reg      <= 1'b0;
            be_reg      <= '0;
            wdata_reg   <= '0;
            rdata_reg   <= '0;
            aw_pend_reg <= 1'b0;
            w_pend_reg  <= 1'b0;
            err_reg     <= 1'b0;
            irq_reg     <= 1'b0;
            cnt_reg     <= 8'd0;
        end else begin
            if (grant) begin
                addr_reg    <= obi_addr_i[AddrWidth-1:2];
                we_reg      <= obi_we_i;
                be_reg      <= obi_be_i;
                wdata_reg   <= obi_wdata_i;
                aw_pend_reg <= obi_we_i;
                w_pend_reg  <= obi_we_i;
            end else if (state_reg == WR) begin
                aw_pend_reg <= aw_left;
                w_pend_reg  <= w_left;
            end

            if (state_reg == WR_B && bvalid_i) begin
                err_reg <= (bresp_i != 2'b00);
            end
            if (state_reg == RD_R && rvalid_i) begin
                rdata_reg <= rdata_i;
                err_reg   <= (rresp_i != 2'b00);
            end

            // Clear wins over a same-cycle error.
            if (err_clr_i) begin
                irq_reg <= 1'b0;
                cnt_reg <= 8'd0;
            end else if (state_reg == RESP && err_reg) begin
                irq_reg <= 1'b1;
                if (cnt_reg != 8'hFF) begin
                    cnt_reg <= cnt_reg + 8'd1;
                end
            end
        end
    end

endmodule
